// File: rtl/injetor_seq_pkg.sv
// Shared definitions for the pipelined Hamming(15,11) error injector:
// mode encodings, LFSR constants and the Galois step function.
package injetor_seq_pkg;

  localparam int          HAM_W        = 15;
  localparam int          HAM_IDXW     = 4;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  // Toggle mask for x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  localparam logic [15:0] LFSR_POLY    = 16'hB400;

  typedef enum logic [1:0] {
    MODO_NONE   = 2'b00,
    MODO_SINGLE = 2'b01,
    MODO_DOUBLE = 2'b10,
    MODO_LFSR   = 2'b11
  } modo_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/injetor_lfsr.sv
// 16-bit Galois LFSR that steps only when enabled; exposes the low index bits.
module injetor_lfsr
  import injetor_seq_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter int          IDXW = HAM_IDXW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [IDXW-1:0] low
);

  logic [15:0] state;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= SEED;
    else if (en) state <= lfsr_next(state);
  end

  assign low = state[IDXW-1:0];

endmodule

// File: rtl/injetor_seq.sv
// Pipelined Hamming error injector: one-register valid/ready stage that flips
// zero, one or two bits per accepted word according to mode and period.
module injetor_seq
  import injetor_seq_pkg::*;
#(
  parameter int          W    = HAM_W,
  parameter int          IDXW = HAM_IDXW,
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    entrada,
  input  logic            erro,
  input  logic [1:0]      modo,
  input  logic [IDXW-1:0] n,
  input  logic [IDXW-1:0] m,
  input  logic [7:0]      periodo,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    saida,
  output logic            injetado,
  output logic [15:0]     total_erros
);

  logic            accept;
  logic            fire;
  logic [7:0]      cnt;
  logic [7:0]      cnt_next;
  logic [7:0]      last;
  logic [W-1:0]    mask;
  logic [IDXW-1:0] lfsr_low;
  logic [IDXW-1:0] rnd_idx;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  injetor_lfsr #(.SEED(SEED), .IDXW(IDXW)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (accept && (modo_e'(modo) == MODO_LFSR)),
    .low (lfsr_low)
  );

  // Out-of-range indices produce an empty mask rather than wrapping.
  function automatic logic [W-1:0] bit_at(input logic [IDXW-1:0] idx);
    bit_at = '0;
    if (int'(idx) < W) bit_at[idx] = 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    last     = ((periodo == 8'd0) ? 8'd1 : periodo) - 8'd1;
    fire     = 1'b0;
    cnt_next = 8'd0;
    if (erro) begin
      if (cnt == last)     fire     = 1'b1;
      else if (cnt < last) cnt_next = cnt + 8'd1;
    end

    rnd_idx = lfsr_low;
    if (int'(rnd_idx) >= W) rnd_idx = rnd_idx - IDXW'(W);

    mask = '0;
    if (fire) begin
      case (modo_e'(modo))
        MODO_SINGLE: mask = bit_at(n);
        MODO_DOUBLE: mask = bit_at(n) | bit_at(m);
        MODO_LFSR:   mask = bit_at(rnd_idx);
        default:     mask = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      saida       <= '0;
      injetado    <= 1'b0;
      total_erros <= 16'h0000;
      cnt         <= 8'd0;
    end else if (accept) begin
      out_valid <= 1'b1;
      saida     <= entrada ^ mask;
      injetado  <= |mask;
      cnt       <= cnt_next;
      if ((|mask) && (total_erros != 16'hFFFF)) total_erros <= total_erros + 16'd1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_injetor_seq.sv
// Scoreboard bench for injetor_seq: a behavioural model predicts each accepted
// word's output, which is compared one cycle later.
module tb_injetor_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] entrada;
  logic        erro;
  logic [1:0]  modo;
  logic [3:0]  n;
  logic [3:0]  m;
  logic [7:0]  periodo;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] saida;
  logic        injetado;
  logic [15:0] total_erros;

  always #5 clk = ~clk;

  injetor_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .entrada     (entrada),
    .erro        (erro),
    .modo        (modo),
    .n           (n),
    .m           (m),
    .periodo     (periodo),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .saida       (saida),
    .injetado    (injetado),
    .total_erros (total_erros)
  );

  typedef struct {
    logic [14:0] saida;
    logic        inj;
    logic [15:0] total;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [7:0]  m_cnt   = 8'd0;
  logic [15:0] m_lfsr  = 16'hACE1;
  logic [15:0] m_total = 16'd0;
  logic [14:0] last_saida;

  task automatic model_reset();
    m_cnt   = 8'd0;
    m_lfsr  = 16'hACE1;
    m_total = 16'd0;
    sb.delete();
  endtask

  // Predicts the result of one accepted word and pushes it to the scoreboard.
  task automatic model_accept();
    logic [7:0]  p;
    logic        f;
    logic [14:0] msk;
    logic [3:0]  idx;
    exp_t        e;
    p   = (periodo == 0) ? 8'd1 : periodo;
    f   = 1'b0;
    msk = '0;
    if (!erro) m_cnt = 0;
    else if (m_cnt == p - 1) begin f = 1'b1; m_cnt = 0; end
    else if (m_cnt > p - 1) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    if (f) begin
      if (modo == 2'b01 && n < 15) msk = 15'(1) << n;
      if (modo == 2'b10) begin
        if (n < 15) msk = msk | (15'(1) << n);
        if (m < 15) msk = msk | (15'(1) << m);
      end
      if (modo == 2'b11) begin
        idx = m_lfsr[3:0];
        if (idx >= 15) idx = idx - 4'd15;
        msk = 15'(1) << idx;
      end
    end
    if (modo == 2'b11) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    if (msk != 0 && m_total != 16'hFFFF) m_total = m_total + 1;
    e.saida = entrada ^ msk;
    e.inj   = (msk != 0);
    e.total = m_total;
    sb.push_back(e);
  endtask

  task automatic send(input logic [14:0] e, input logic er, input logic [1:0] md,
                      input logic [3:0] nn, input logic [3:0] mm, input logic [7:0] per);
    @(negedge clk);
    in_valid = 1'b1; entrada = e; erro = er; modo = md; n = nn; m = mm; periodo = per;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: in_ready=%b expected 1", in_ready);
    end else begin
      model_accept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected word queued", name);
      return;
    end
    e = sb.pop_front();
    last_saida = e.saida;
    if (out_valid !== 1'b1 || saida !== e.saida || injetado !== e.inj || total_erros !== e.total) begin
      errors++;
      $display("FAIL %s: got valid=%b saida=%h inj=%b total=%0d, expected valid=1 saida=%h inj=%b total=%0d",
               name, out_valid, saida, injetado, total_erros, e.saida, e.inj, e.total);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; entrada = '0; erro = 1'b0; modo = 2'b00;
    n = '0; m = '0; periodo = 8'd1; out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || saida !== 15'h0 || injetado !== 1'b0 || total_erros !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b saida=%h inj=%b total=%0d ready=%b, expected 0 0 0 0 1",
               out_valid, saida, injetado, total_erros, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    send(15'h0000, 1'b1, 2'b01, 4'd3, 4'd0, 8'd1);
    check_out("single_n3");
    checks++;
    if (saida !== 15'h0008 || total_erros !== 16'd1) begin
      errors++;
      $display("FAIL single_const: saida=%h total=%0d expected 0008 1", saida, total_erros);
    end
    send(15'h1234, 1'b1, 2'b01, 4'd15, 4'd0, 8'd1);
    check_out("single_out_of_range");
    send(15'h1234, 1'b0, 2'b01, 4'd3, 4'd0, 8'd1);
    check_out("single_erro_off");
    idle();
  endtask

  task automatic test_double();
    send(15'h7FFF, 1'b1, 2'b10, 4'd0, 4'd14, 8'd0);
    check_out("double_0_14");
    send(15'h0000, 1'b1, 2'b10, 4'd5, 4'd5, 8'd0);
    check_out("double_same");
    checks++;
    if (saida !== 15'h0020 || injetado !== 1'b1) begin
      errors++;
      $display("FAIL double_same_const: saida=%h inj=%b expected 0020 1", saida, injetado);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [15:0] start;
    send(15'h0000, 1'b0, 2'b01, 4'd0, 4'd0, 8'd3);
    check_out("period_clear");
    start = total_erros;
    for (int i = 1; i <= 6; i++) begin
      send(15'h0000, 1'b1, 2'b01, 4'd0, 4'd0, 8'd3);
      check_out($sformatf("period_word%0d", i));
    end
    checks++;
    if (total_erros - start !== 16'd2) begin
      errors++;
      $display("FAIL period_count: injected=%0d expected 2", total_erros - start);
    end
    idle();
  endtask

  task automatic test_backpressure();
    send(15'h0F0F, 1'b1, 2'b11, 4'd0, 4'd0, 8'd1);
    check_out("bp_first");
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; entrada = 15'h5555; modo = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || saida !== last_saida) begin
        errors++;
        $display("FAIL bp_hold%0d: ready=%b valid=%b saida=%h expected 0 1 %h",
                 i, in_ready, out_valid, saida, last_saida);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b expected 1", in_ready);
    end else begin
      model_accept();
    end
    @(posedge clk);
    #1;
    check_out("bp_after_release");
    for (int i = 0; i < 5; i++) begin
      send(15'(i * 15'h0111), 1'b1, 2'b11, 4'd0, 4'd0, 8'd1);
      check_out($sformatf("bp_lfsr%0d", i));
    end
    idle();
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      send(15'h0000, 1'b1, 2'b01, 4'd2, 4'd0, 8'd1);
      check_out($sformatf("pre_reset%0d", i));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || total_erros !== 16'h0 || saida !== 15'h0 || injetado !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b total=%0d saida=%h inj=%b expected 0 0 0 0",
               out_valid, total_erros, saida, injetado);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    model_reset();
    send(15'h0000, 1'b1, 2'b11, 4'd0, 4'd0, 8'd1);
    check_out("post_reset_lfsr");
    checks++;
    if (saida !== 15'h0002) begin
      errors++;
      $display("FAIL post_reset_seed_idx: saida=%h expected 0002", saida);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/injetor_seq.md
Name: injetor_seq

Overview:
- Parametrised, pipelined successor of the combinational Hamming error injector.
- Sits between the Hamming encoder and decoder in the test path.
- Takes codewords on a valid/ready stream and flips zero, one or two bits per word.
- Supports selectable modes (fixed single, fixed double, pseudo-random single) and a programmable injection period; counts injected errors.

Parameters:
- W, 15: codeword width in bits.
- IDXW, 4: bit-index width, equal to ceil(log2(W)).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- entrada  in  W  input codeword.
- erro  in  1  injection enable.
- modo  in  2  mode: 00 none, 01 single at n, 10 double at n and m, 11 LFSR random single.
- n  in  IDXW  first bit index.
- m  in  IDXW  second bit index (mode 10 only).
- periodo  in  8  inject on every periodo-th accepted word; 0 and 1 both mean every word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word.
- saida  out  W  output codeword.
- injetado  out  1  at least one bit flipped in the current saida; aligned with saida.
- total_erros  out  16  count of words with injetado=1; saturates at 16'hFFFF.

Behaviour:
- Reset (async, immediate): out_valid=0, saida=0, injetado=0, total_erros=0, period counter=0, lfsr=SEED.
- Handshake:
  - Single output register, no skid: in_ready = !out_valid || out_ready.
  - Accept when in_valid && in_ready.
  - Latency is exactly 1 cycle: saida, injetado and out_valid update on the edge after acceptance.
  - out_valid clears when the word is consumed and no new word is accepted.
  - While out_valid && !out_ready: saida, injetado, out_valid and all internal state hold.
- Period counter (8 bit), advances only on accepted words:
  - erro=0: counter forced to 0; no injection.
  - erro=1, effective period P = max(periodo,1): fire = (counter == P-1).
  - On fire the counter goes to 0; otherwise it increments.
  - Changing periodo mid-stream takes effect on the next accepted word. If counter > P-1, the counter wraps to 0 with no fire.
- Mask computation on an accepted word with fire=1 (mask=0 if fire=0):
  - modo 00: mask=0.
  - modo 01: mask bit n set. If n >= W, mask=0 (out-of-range index is a no-op).
  - modo 10: mask = bit n OR bit m, each ignored if >= W. n==m gives a single flip, not a cancellation.
  - modo 11: idx = lfsr[IDXW-1:0]; if idx >= W, idx = idx - W (always < W since 2^IDXW < 2W); mask = bit idx.
- Output on an accepted word:
  - saida <= entrada XOR mask.
  - injetado <= (mask != 0).
  - total_erros increments by 1 when mask != 0, saturating.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances once per accepted word while modo=11, regardless of fire; holds otherwise.
- Simultaneous accept and consume: the new word replaces the old in the same edge; out_valid stays 1.
- Mode/index inputs are sampled only on the accepting edge.

Decomposition:
- Shared package: mode encodings (MODO_NONE, MODO_SINGLE, MODO_DOUBLE, MODO_LFSR), LFSR polynomial constant, default SEED, W=15/IDXW=4 Hamming(15,11) constants.
- One natural sub-module: injetor_lfsr (16-bit Galois LFSR with advance enable and async reset).
- Mask generation and the period counter stay inline.

Test Plan:
- W=15, modo=01, n=3, periodo=1, erro=1, entrada=15'h0000, out_ready=1 -> next cycle saida=15'h0008, injetado=1, total_erros=1.
- modo=01, n=15 (out of range), entrada=15'h1234 -> saida=15'h1234, injetado=0, total_erros unchanged; then erro=0 with n=3 -> saida equals entrada.
- modo=10, n=0, m=14, entrada=15'h7FFF -> saida=15'h3FFE. Then n=m=5, entrada=15'h0000 -> saida=15'h0020, injetado=1.
- modo=01, n=0, periodo=3, six back-to-back words of 15'h0000 -> saida=15'h0001 only on words 3 and 6, total_erros=2.
- out_ready=0 for 3 cycles with in_valid=1, modo=11 -> in_ready=0, saida stable, LFSR and counter frozen. On release, the flipped-index sequence matches a software Galois LFSR model from SEED with no skipped or duplicated index.
- Assert rst mid-stream with out_valid=1, total_erros=5 -> out_valid=0 and total_erros=0 immediately (before the next edge). The first modo=11 word after reset flips the index derived from SEED.
